conv_channel_accum_14: RTL and testbench

- Sits directly downstream of the 14x14 pre-convolution stage. Consumes its stream of signed 48-bit per-channel partial sums, one per pixel in raster order.
- Accumulates partial sums across NUM_IN_CH input channels in an internal frame buffer.
- On the last channel it adds the output-channel bias, requantizes by an arithmetic right shift, applies ReLU, saturates, and emits a signed 16-bit activation stream for the next layer.

---
 rtl/conv_channel_accum_14_pkg.sv | 11 +
 rtl/conv_channel_accum_14_requant_relu.sv | 31 +++
 rtl/conv_channel_accum_14.sv | 134 +++++++++++++
 tb/tb_conv_channel_accum_14.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_channel_accum_14_pkg.sv
// Shared CNN datapath constants and word types for the channel accumulator.
package cnn_pkg;

  localparam int ACC_W   = 48;
  localparam int PIX_W   = 16;
  localparam int FMAP_14 = 14;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [PIX_W-1:0] pix_t;

endpackage

// File: rtl/conv_channel_accum_14_requant_relu.sv
// Requantizer: floor right shift, ReLU clamp at zero, saturate at the
// largest positive OUT_W value. Purely combinational.
module requant_relu
  import cnn_pkg::*;
#(
  parameter int ACC_W      = cnn_pkg::ACC_W,
  parameter int OUT_W      = cnn_pkg::PIX_W,
  parameter int FRAC_SHIFT = 8
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic signed [OUT_W-1:0] q
);

  localparam logic signed [ACC_W-1:0] MAX_POS =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};

  logic signed [ACC_W-1:0] shifted_s;

  // Shift, then clamp negatives to zero and large positives to the top code.
  always_comb begin
    shifted_s = sum >>> FRAC_SHIFT;
    if (shifted_s[ACC_W-1]) begin
      q = {OUT_W{1'b0}};
    end else if (shifted_s > MAX_POS) begin
      q = {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      q = shifted_s[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/conv_channel_accum_14.sv
// Per-pixel accumulation of partial sums across input channels. The frame
// buffer carries running sums for channels 0..N-2; the last channel adds the
// bias, requantizes and emits one activation per pixel.
module conv_channel_accum_14
  import cnn_pkg::*;
#(
  parameter int IMG_SIZE   = cnn_pkg::FMAP_14,
  parameter int NUM_IN_CH  = 4,
  parameter int ACC_W      = cnn_pkg::ACC_W,
  parameter int OUT_W      = cnn_pkg::PIX_W,
  parameter int FRAC_SHIFT = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic signed [ACC_W-1:0]       psum_in,
  input  logic                          valid_in,
  input  logic signed [OUT_W-1:0]       bias,
  output logic signed [OUT_W-1:0]       pixel_out,
  output logic                          valid_out,
  output logic                          frame_done,
  output logic [$clog2(NUM_IN_CH):0]    ch_idx,
  output logic                          busy
);

  localparam int PIXELS = IMG_SIZE * IMG_SIZE;
  localparam int PIX_CW = $clog2(PIXELS);
  localparam int CH_W   = $clog2(NUM_IN_CH) + 1;
  localparam logic [PIX_CW-1:0] LAST_PIX = PIX_CW'(PIXELS - 1);
  localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_IN_CH - 1);

  logic [PIX_CW-1:0]       pix_cnt_r;
  logic [PIX_CW-1:0]       pix_nxt_s;
  logic [CH_W-1:0]         ch_nxt_s;
  logic                    beat_s;
  logic                    last_ch_s;
  logic                    last_pix_s;
  logic signed [ACC_W-1:0] rd_s;
  logic signed [ACC_W-1:0] bias_term_s;
  logic signed [ACC_W-1:0] sum_s;
  logic signed [OUT_W-1:0] q_s;

  // A clear in the same cycle as valid_in drops that beat entirely.
  assign beat_s     = valid_in & ~clear;
  assign last_ch_s  = (ch_idx == LAST_CH);
  assign last_pix_s = (pix_cnt_r == LAST_PIX);

  generate
    if (NUM_IN_CH > 1) begin : g_buf
      logic signed [ACC_W-1:0] mem_r [PIXELS];
      logic signed [ACC_W-1:0] acc_nxt_s;

      assign rd_s = mem_r[pix_cnt_r];

      // Channel 0 seeds the entry so stale data is never summed; later channels add.
      always_comb begin
        if (ch_idx == {CH_W{1'b0}}) begin
          acc_nxt_s = psum_in;
        end else begin
          acc_nxt_s = rd_s + psum_in;
        end
      end

      // Buffer write on every non-final-channel beat; no reset on the storage.
      always_ff @(posedge clk) begin
        if (beat_s && !last_ch_s) begin
          mem_r[pix_cnt_r] <= acc_nxt_s;
        end
      end
    end else begin : g_nobuf
      assign rd_s = {ACC_W{1'b0}};
    end
  endgenerate

  // Final-channel sum: buffered partials plus this beat plus scaled bias.
  always_comb begin
    bias_term_s = {{(ACC_W-OUT_W){bias[OUT_W-1]}}, bias} <<< FRAC_SHIFT;
    sum_s       = rd_s + psum_in + bias_term_s;
  end

  requant_relu #(
    .ACC_W      (ACC_W),
    .OUT_W      (OUT_W),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_requant (
    .sum (sum_s),
    .q   (q_s)
  );

  // Next pixel/channel position; frames follow each other with no gap.
  always_comb begin
    pix_nxt_s = pix_cnt_r;
    ch_nxt_s  = ch_idx;
    if (clear) begin
      pix_nxt_s = {PIX_CW{1'b0}};
      ch_nxt_s  = {CH_W{1'b0}};
    end else if (valid_in) begin
      if (last_pix_s) begin
        pix_nxt_s = {PIX_CW{1'b0}};
        if (last_ch_s) begin
          ch_nxt_s = {CH_W{1'b0}};
        end else begin
          ch_nxt_s = ch_idx + CH_W'(1);
        end
      end else begin
        pix_nxt_s = pix_cnt_r + PIX_CW'(1);
      end
    end else begin
      pix_nxt_s = pix_cnt_r;
    end
  end

  // Counters, registered activation output, frame pulse and busy flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_cnt_r  <= {PIX_CW{1'b0}};
      ch_idx     <= {CH_W{1'b0}};
      pixel_out  <= {OUT_W{1'b0}};
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      pix_cnt_r  <= pix_nxt_s;
      ch_idx     <= ch_nxt_s;
      busy       <= (pix_nxt_s != {PIX_CW{1'b0}}) || (ch_nxt_s != {CH_W{1'b0}});
      valid_out  <= beat_s && last_ch_s;
      frame_done <= beat_s && last_ch_s && last_pix_s;
      if (beat_s && last_ch_s) begin
        pixel_out <= q_s;
      end
    end
  end

endmodule

// File: tb/tb_conv_channel_accum_14.sv
// Self-checking bench: requantizer vector table, a single-channel instance
// and a four-channel instance driven frame by frame against a scoreboard.
module tb_conv_channel_accum_14;
  import cnn_pkg::*;

  typedef struct {
    longint pix;
    bit     fd;
    longint cyc;
  } exp_t;

  typedef struct {
    longint sum;
    longint q;
    string  name;
  } rq_vec_t;

  logic clk;
  logic reset;
  longint cyc = 0;

  logic clear4, valid4, vout4, fd4, busy4;
  acc_t psum4;
  pix_t bias4, pix_out4;
  logic [2:0] ch4;

  logic clear1, valid1, vout1, fd1, busy1;
  acc_t psum1;
  pix_t bias1, pix_out1;
  logic [0:0] ch1;

  acc_t rq_sum;
  pix_t rq_q;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fd4_seen = 0;
  int fd1_seen = 0;
  exp_t q4[$];
  exp_t q1[$];
  exp_t e4, e1;
  bit exp_v4, exp_v1;

  conv_channel_accum_14 #(.IMG_SIZE(14), .NUM_IN_CH(4), .ACC_W(48), .OUT_W(16), .FRAC_SHIFT(8)) dut4 (
    .clk(clk), .reset(reset), .clear(clear4), .psum_in(psum4), .valid_in(valid4), .bias(bias4),
    .pixel_out(pix_out4), .valid_out(vout4), .frame_done(fd4), .ch_idx(ch4), .busy(busy4));

  conv_channel_accum_14 #(.IMG_SIZE(14), .NUM_IN_CH(1), .ACC_W(48), .OUT_W(16), .FRAC_SHIFT(8)) dut1 (
    .clk(clk), .reset(reset), .clear(clear1), .psum_in(psum1), .valid_in(valid1), .bias(bias1),
    .pixel_out(pix_out1), .valid_out(vout1), .frame_done(fd1), .ch_idx(ch1), .busy(busy1));

  requant_relu #(.ACC_W(48), .OUT_W(16), .FRAC_SHIFT(8)) u_rq (.sum(rq_sum), .q(rq_q));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference requantizer: 48-bit wrap, floor shift, ReLU, saturate.
  function automatic longint model_q(input longint s);
    longint w, q;
    w = (s <<< 16) >>> 16;
    q = w >>> 8;
    if (q < 0) return 0;
    if (q > 32767) return 32767;
    return q;
  endfunction

  function automatic longint psum_of(input int pat, input int ch, input int pix);
    case (pat)
      0: return longint'(pix) * 256;
      1: return -64'sd4096;
      2: return 64'sh7FFFFF;
      3: return (longint'((pix * 97 + ch * 1231) % 4096) - 1024) * 64;
      4: return (longint'(pix) - 98) * 262144;
      default: return 0;
    endcase
  endfunction

  // Scoreboard for the four-channel instance: output exactly one cycle after the final-channel beat.
  always @(negedge clk) begin
    if (reset) begin
      if (fd4) fd4_seen++;
      exp_v4 = (q4.size() > 0) && (q4[0].cyc == cyc);
      check("dut4 valid_out", vout4, exp_v4);
      if (exp_v4) begin
        e4 = q4.pop_front();
        check("dut4 pixel_out", pix_out4, e4.pix);
        check("dut4 frame_done", fd4, e4.fd);
      end else begin
        check("dut4 frame_done idle", fd4, 0);
      end
    end
  end

  // Scoreboard for the single-channel instance.
  always @(negedge clk) begin
    if (reset) begin
      if (fd1) fd1_seen++;
      exp_v1 = (q1.size() > 0) && (q1[0].cyc == cyc);
      check("dut1 valid_out", vout1, exp_v1);
      if (exp_v1) begin
        e1 = q1.pop_front();
        check("dut1 pixel_out", pix_out1, e1.pix);
        check("dut1 frame_done", fd1, e1.fd);
      end else begin
        check("dut1 frame_done idle", fd1, 0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid4 = 1'b0; clear4 = 1'b0; valid1 = 1'b0; clear1 = 1'b0;
    end
  endtask

  task automatic beat4(input longint p, input int b, input bit last, input longint e, input bit fd);
    exp_t x;
    @(negedge clk);
    psum4 = p[47:0]; bias4 = b[15:0]; valid4 = 1'b1; clear4 = 1'b0;
    if (last) begin
      x.pix = e; x.fd = fd; x.cyc = cyc + 1;
      q4.push_back(x);
    end
  endtask

  // Drive one frame; optionally stop at (stop_ch, stop_pix), issuing clear with that beat.
  task automatic run_frame4(input int pat, input int b, input int stop_ch, input int stop_pix, input bit do_clear);
    longint s;
    for (int ch = 0; ch < 4; ch++) begin
      for (int pix = 0; pix < 196; pix++) begin
        if (ch == stop_ch && pix == stop_pix) begin
          if (do_clear) begin
            @(negedge clk);
            check("dut4 ch_idx before clear", ch4, stop_ch);
            check("dut4 busy mid-frame", busy4, 1);
            psum4 = psum_of(pat, ch, pix) & 64'hFFFF_FFFF_FFFF; bias4 = b[15:0];
            valid4 = 1'b1; clear4 = 1'b1;
          end
          return;
        end
        s = longint'(b) * 256;
        for (int c = 0; c < 4; c++) s += psum_of(pat, c, pix);
        beat4(psum_of(pat, ch, pix), b, ch == 3, model_q(s), pix == 195);
      end
    end
  endtask

  initial begin
    rq_vec_t vt[12];
    exp_t x;
    int fd_before;

    vt[0]  = '{sum: 64'sd0,                    q: 0,     name: "rq zero"};
    vt[1]  = '{sum: 64'sh400,                  q: 4,     name: "rq exact"};
    vt[2]  = '{sum: 64'sh4FF,                  q: 4,     name: "rq floor"};
    vt[3]  = '{sum: -64'sd1,                   q: 0,     name: "rq minus one"};
    vt[4]  = '{sum: -64'sd4096,                q: 0,     name: "rq negative"};
    vt[5]  = '{sum: 64'sh7FFFFF,               q: 32767, name: "rq max exact"};
    vt[6]  = '{sum: 64'sh7FFEFF,               q: 32766, name: "rq below max"};
    vt[7]  = '{sum: 64'sh800000,               q: 32767, name: "rq sat edge"};
    vt[8]  = '{sum: 64'sh0000_7FFF_FFFF_FFFF,  q: 32767, name: "rq sat big"};
    vt[9]  = '{sum: 64'shFFFF_8000_0000_0000,  q: 0,     name: "rq most negative"};
    vt[10] = '{sum: 64'shFF,                   q: 0,     name: "rq sub one"};
    vt[11] = '{sum: 64'sh12345,                q: 291,   name: "rq mid"};

    reset = 1'b0;
    clear4 = 1'b0; valid4 = 1'b0; psum4 = '0; bias4 = '0;
    clear1 = 1'b0; valid1 = 1'b0; psum1 = '0; bias1 = '0;
    rq_sum = '0;
    #3;
    check("reset pixel_out", pix_out4, 0);
    check("reset valid_out", vout4, 0);
    check("reset frame_done", fd4, 0);
    check("reset busy", busy4, 0);
    check("reset ch_idx", ch4, 0);
    check("reset dut1 busy", busy1, 0);
    check("reset dut1 ch_idx", ch1, 0);

    for (int i = 0; i < 12; i++) begin
      rq_sum = vt[i].sum[47:0];
      #1;
      check(vt[i].name, rq_q, vt[i].q);
    end

    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Single channel: every beat is the last channel.
    for (int p = 0; p < 196; p++) begin
      @(negedge clk);
      psum1 = 48'sh300; bias1 = 16'sd1; valid1 = 1'b1;
      x.pix = model_q(64'sh300 + 64'sh100); x.fd = (p == 195); x.cyc = cyc + 1;
      q1.push_back(x);
    end
    idle(3);
    check("dut1 frame_done count", fd1_seen, 1);

    // Four channels: ramp, negative, saturating.
    run_frame4(0, 0, -1, -1, 1'b0);
    idle(2);
    run_frame4(1, 0, -1, -1, 1'b0);
    idle(2);
    run_frame4(2, 0, -1, -1, 1'b0);
    idle(2);

    // Back-to-back frames with valid_in held high throughout.
    fd_before = fd4_seen;
    run_frame4(3, -5, -1, -1, 1'b0);
    run_frame4(4, 100, -1, -1, 1'b0);
    idle(3);
    check("dut4 back-to-back frame_done pulses", fd4_seen - fd_before, 2);

    // Abort with clear at channel 2, pixel 50, then a clean frame.
    run_frame4(3, 7, 2, 50, 1'b1);
    idle(1);
    check("dut4 ch_idx after clear", ch4, 0);
    check("dut4 busy after clear", busy4, 0);
    run_frame4(3, 7, -1, -1, 1'b0);
    idle(2);

    // Asynchronous reset mid-frame, during last-channel output.
    run_frame4(0, 0, 3, 20, 1'b0);
    @(posedge clk);
    #2;
    check("dut4 pixel_out before reset", pix_out4, 76);
    reset = 1'b0;
    valid4 = 1'b0;
    q4.delete();
    #1;
    check("async reset valid_out", vout4, 0);
    check("async reset pixel_out", pix_out4, 0);
    check("async reset busy", busy4, 0);
    check("async reset ch_idx", ch4, 0);
    @(negedge clk);
    reset = 1'b1;
    fd_before = fd4_seen;
    run_frame4(4, -3, -1, -1, 1'b0);
    idle(3);
    check("dut4 frame_done after reset", fd4_seen - fd_before, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
